// File: rtl/dmemory_pipe.sv
// Byte-lane data memory with valid/ready request port; DMEM_MISALIGN_FAULT_EN makes misaligned accesses fault.
// Response exactly one cycle after accept, full throughput; stalls (req_ready=0) only during reset or init_en.
module dmemory_pipe #(
    parameter int          NUM_LANES   = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h01000000,
    parameter int          DEPTH_BYTES = 1048576
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [31:0]            req_addr,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [8*NUM_LANES-1:0] req_wdata,
    output logic                   resp_valid,
    output logic [8*NUM_LANES-1:0] resp_rdata,
    output logic                   resp_fault,
    input  logic                   init_en,
    input  logic [31:0]            init_addr,
    input  logic [8*NUM_LANES-1:0] init_wdata
);

    localparam int W     = 8 * NUM_LANES;
    localparam int LW    = $clog2(NUM_LANES);
    localparam int WORDS = DEPTH_BYTES / NUM_LANES;
    localparam int IW    = $clog2(WORDS);

    logic [7:0] mem [NUM_LANES][WORDS];

    logic           req_acc;
    logic [31:0]    req_off;
    logic [3:0]     req_nbytes;
    logic [32:0]    req_end;
    logic           req_flt;
    logic [LW-1:0]  req_lane;
    logic [IW-1:0]  req_idx;
    logic [IW-1:0]  req_idx_nxt;

    logic [31:0]    init_off;
    logic           init_hit;
    logic [IW-1:0]  init_idx;

    logic [NUM_LANES-1:0] wr_en;
    logic [IW-1:0]        wr_idx  [NUM_LANES];
    logic [7:0]           wr_byte [NUM_LANES];
    logic [IW-1:0]        rd_idx  [NUM_LANES];

    logic           resp_vld_d, resp_vld_q;
    logic           resp_flt_d, resp_flt_q;
    logic           resp_ld_d,  resp_ld_q;
    logic [LW-1:0]  rot_d,      rot_q;
    logic [1:0]     size_d,     size_q;
    logic           uns_d,      uns_q;
    logic [W-1:0]   rd_dat_d,   rd_dat_q;

    logic [W-1:0]   rot_dat;
    logic [W-1:0]   ext_dat;
    logic [3:0]     nb_q;
    logic           sign_bit;

    // Request decode: range/size/alignment checks and lane/word mapping.
    always_comb begin
        req_ready   = !reset && !init_en;
        req_acc     = req_valid && req_ready;
        req_off     = req_addr - BASE_ADDR;
        req_nbytes  = 4'd1 << req_size;
        req_end     = {1'b0, req_off} + 33'(req_nbytes);
        req_flt     = (req_end > 33'(DEPTH_BYTES)) || (req_nbytes > 4'(NUM_LANES));
`ifdef DMEM_MISALIGN_FAULT_EN
        req_flt     = req_flt || ((req_off[3:0] & (req_nbytes - 4'd1)) != 4'd0);
`endif
        req_lane    = req_off[LW-1:0];
        req_idx     = req_off[LW +: IW];
        req_idx_nxt = req_idx + IW'(1);

        init_off    = init_addr - BASE_ADDR;
        init_hit    = init_en && !reset && (init_off < 32'(DEPTH_BYTES));
        init_idx    = init_off[LW +: IW];
    end

    // Per-lane write port; lanes below the start lane belong to the next word.
    always_comb begin
        logic [LW-1:0] pos;
        logic          in_span;
        pos     = '0;
        in_span = 1'b0;
        wr_en   = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            pos       = LW'(l) - req_lane;
            in_span   = 4'(pos) < req_nbytes;
            rd_idx[l] = (LW'(l) < req_lane) ? req_idx_nxt : req_idx;
            if (init_hit) begin
                wr_en[l]   = 1'b1;
                wr_idx[l]  = init_idx;
                wr_byte[l] = init_wdata[8*l +: 8];
            end else begin
                wr_en[l]   = req_acc && req_write && !req_flt && in_span;
                wr_idx[l]  = rd_idx[l];
                wr_byte[l] = req_wdata[8*int'(pos) +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (wr_en[l]) begin
                mem[l][wr_idx[l]] <= wr_byte[l];
            end
        end
    end

    always_comb begin
        resp_vld_d = req_acc;
        resp_flt_d = req_acc && req_flt;
        resp_ld_d  = req_acc && !req_write && !req_flt;
        rot_d      = req_lane;
        size_d     = req_size;
        uns_d      = req_unsigned;
        rd_dat_d   = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            rd_dat_d[8*l +: 8] = mem[l][rd_idx[l]];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_vld_q <= 1'b0;
            resp_flt_q <= 1'b0;
            resp_ld_q  <= 1'b0;
            rot_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            rd_dat_q   <= '0;
        end else begin
            resp_vld_q <= resp_vld_d;
            resp_flt_q <= resp_flt_d;
            resp_ld_q  <= resp_ld_d;
            rot_q      <= rot_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            rd_dat_q   <= rd_dat_d;
        end
    end

    // Response: rotate lanes back to byte order, then mask and extend.
    always_comb begin
        logic [LW-1:0] sel;
        sel      = '0;
        rot_dat  = '0;
        ext_dat  = '0;
        sign_bit = 1'b0;
        nb_q     = 4'd1 << size_q;
        for (int k = 0; k < NUM_LANES; k++) begin
            sel = rot_q + LW'(k);
            rot_dat[8*k +: 8] = rd_dat_q[8*int'(sel) +: 8];
        end
        for (int k = 0; k < NUM_LANES; k++) begin
            if (4'(k) == nb_q - 4'd1) begin
                sign_bit = rot_dat[8*k + 7];
            end
        end
        sign_bit = sign_bit && !uns_q;
        for (int k = 0; k < NUM_LANES; k++) begin
            ext_dat[8*k +: 8] = (4'(k) < nb_q) ? rot_dat[8*k +: 8] : {8{sign_bit}};
        end

        resp_valid = resp_vld_q && !reset;
        resp_fault = resp_flt_q && !reset;
        resp_rdata = (resp_ld_q && !reset) ? ext_dat : '0;
    end

endmodule

// File: tb/tb_dmemory_pipe.sv
// Randomized bench for dmemory_pipe against a byte-array reference model.
// Inputs driven #1 after posedge, outputs sampled on negedge.
module tb_dmemory_pipe;

    localparam int          NL    = 4;
    localparam int          W     = 8 * NL;
    localparam logic [31:0] BASE  = 32'h01000000;
    localparam int          DEPTH = 4096;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [1:0]    req_size = '0;
    logic          req_unsigned = 1'b0;
    logic [W-1:0]  req_wdata = '0;
    logic          resp_valid;
    logic [W-1:0]  resp_rdata;
    logic          resp_fault;
    logic          init_en = 1'b0;
    logic [31:0]   init_addr = '0;
    logic [W-1:0]  init_wdata = '0;

    dmemory_pipe #(.NUM_LANES(NL), .BASE_ADDR(BASE), .DEPTH_BYTES(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .init_en(init_en), .init_addr(init_addr),
        .init_wdata(init_wdata)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [7:0]   mm [DEPTH];
    logic         pend = 1'b0;
    logic         exp_flt = 1'b0;
    logic [W-1:0] exp_rd = '0;
    logic [W-1:0] last_rdata = '0;
    logic         last_fault = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_access(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                                input logic uns, input logic [W-1:0] wd,
                                output logic flt, output logic [W-1:0] rd);
        logic [63:0] off;
        int n;
        off = {32'd0, addr - BASE};
        n   = 1 << sz;
        flt = (off + 64'(n) > 64'(DEPTH)) || (n > NL);
`ifdef DMEM_MISALIGN_FAULT_EN
        if (off % 64'(n) != 0) flt = 1'b1;
`endif
        rd = '0;
        if (!flt) begin
            if (wr) begin
                for (int i = 0; i < n; i++) mm[int'(off) + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) rd[8*i +: 8] = mm[int'(off) + i];
                if (!uns && n < NL && rd[8*n-1]) begin
                    for (int i = n; i < NL; i++) rd[8*i +: 8] = 8'hFF;
                end
            end
        end
    endtask

    task automatic model_init(input logic [31:0] ia, input logic [W-1:0] iw);
        logic [31:0] off;
        int base_b;
        off = ia - BASE;
        if (off < 32'(DEPTH)) begin
            base_b = int'(off / NL) * NL;
            for (int i = 0; i < NL; i++) mm[base_b + i] = iw[8*i +: 8];
        end
    endtask

    task automatic step(input logic rst, input logic vld, input logic wr,
                        input logic [31:0] addr, input logic [1:0] sz, input logic uns,
                        input logic [W-1:0] wd, input logic ie,
                        input logic [31:0] ia, input logic [W-1:0] iw);
        @(posedge clock);
        #1;
        reset = rst; req_valid = vld; req_write = wr; req_addr = addr;
        req_size = sz; req_unsigned = uns; req_wdata = wd;
        init_en = ie; init_addr = ia; init_wdata = iw;
        @(negedge clock);
        chk("resp_valid", resp_valid, pend && !rst);
        if (pend && !rst) begin
            chk("resp_fault", resp_fault, exp_flt);
            chk("resp_rdata", resp_rdata, exp_rd);
            last_rdata = resp_rdata;
            last_fault = resp_fault;
        end
        if (rst) begin
            chk("rst_rdata", resp_rdata, 0);
            chk("rst_fault", resp_fault, 0);
        end
        chk("req_ready", req_ready, !rst && !ie);
        pend = vld && !rst && !ie;
        if (pend) model_access(wr, addr, sz, uns, wd, exp_flt, exp_rd);
        if (ie && !rst) model_init(ia, iw);
    endtask

    task automatic idle();
        step(0, 0, 0, '0, 2'd0, 0, '0, 0, '0, '0);
    endtask

    task automatic rq(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                      input logic uns, input logic [W-1:0] wd);
        step(0, 1, wr, addr, sz, uns, wd, 0, '0, '0);
    endtask

    initial begin
        // Reset: two cycles, nothing ready, nothing valid.
        step(1, 1, 0, BASE, 2'd2, 0, '0, 0, '0, '0);
        step(1, 1, 0, BASE, 2'd2, 0, '0, 1, BASE, 32'h12345678);
        idle();

        // Load the whole memory; a core load is held pending over the first words.
        for (int w = 0; w < DEPTH / NL; w++) begin
            step(0, 1, 0, BASE + 32'd8, 2'd2, 0, '0, 1, BASE + 32'(w * NL), $urandom);
        end
        rq(0, BASE + 32'd8, 2'd2, 0, '0);
        idle();

        // Store then load word.
        rq(1, BASE + 32'd4, 2'd2, 0, 32'hDEADBEEF);
        rq(0, BASE + 32'd4, 2'd2, 0, '0);
        idle();
        chk("t2_word", last_rdata, 32'hDEADBEEF);

        // Sub-word loads, back to back.
        rq(0, BASE + 32'd7, 2'd0, 0, '0);
        rq(0, BASE + 32'd7, 2'd0, 1, '0);
        chk("t3_byte_s", last_rdata, 32'hFFFFFFDE);
        rq(0, BASE + 32'd6, 2'd1, 0, '0);
        chk("t3_byte_u", last_rdata, 32'h000000DE);
        idle();
        chk("t3_half_s", last_rdata, 32'hFFFFDEAD);

        // Misaligned word store across a word boundary.
        rq(1, BASE + 32'd3, 2'd2, 0, 32'h11223344);
        rq(0, BASE + 32'd3, 2'd0, 1, '0);
`ifdef DMEM_MISALIGN_FAULT_EN
        chk("t4_st_fault", last_fault, 1);
`else
        chk("t4_st_fault", last_fault, 0);
`endif
        rq(0, BASE + 32'd4, 2'd1, 1, '0);
`ifndef DMEM_MISALIGN_FAULT_EN
        chk("t4_byte3", last_rdata, 32'h00000044);
`endif
        rq(0, BASE + 32'd3, 2'd2, 0, '0);
`ifndef DMEM_MISALIGN_FAULT_EN
        chk("t4_half4", last_rdata, 32'h00002233);
`endif
        idle();
`ifdef DMEM_MISALIGN_FAULT_EN
        chk("t4_ld_fault", last_fault, 1);
`else
        chk("t4_word", last_rdata, 32'h11223344);
`endif

        // Range and size faults.
        rq(0, BASE - 32'd1, 2'd2, 0, '0);
        rq(0, BASE + 32'(DEPTH - 2), 2'd2, 0, '0);
        chk("t5_below", last_fault, 1);
        chk("t5_below_rd", last_rdata, 0);
        rq(0, BASE, 2'd3, 0, '0);
        chk("t5_above", last_fault, 1);
        rq(0, BASE + 32'(DEPTH - 4), 2'd2, 0, '0);
        chk("t5_dword", last_fault, 1);
        idle();
        chk("t5_last_ok", last_fault, 0);

        // Randomized traffic with occasional init and reset.
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 1) == 1) ? BASE + 32'($urandom_range(0, 31))
                                            : BASE - 32'd4 + 32'($urandom_range(0, DEPTH + 8));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom,
                 $urandom_range(0, 15) == 0,
                 BASE - 32'd8 + 32'($urandom_range(0, DEPTH + 15)), $urandom);
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
